// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a program over a valid/ready stream, then serves 1-cycle fetches.
// Optional macro IMEM_LOADER_CHKSUM_EN makes the final word conditional on a running-sum checksum match.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [31:0]       chk_exp,
  output logic              start,
  output logic              load_err,
  output logic [ADDR_W:0]   loaded_count,
  output logic [31:0]       chksum,
  input  logic              imem_en,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {LOAD, RUN, ERR} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready_q;
  logic              accept;
  logic              at_end;
  logic              chk_ok;
  logic              in_range;

  assign ld_ready = ready_q;
  assign accept   = ld_valid && ready_q;
  assign at_end   = &loaded_count[ADDR_W-1:0];
  assign start    = (state == RUN);
  assign load_err = (state == ERR);
  assign in_range = ({1'b0, imem_addr} < loaded_count);

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [31:0] word32;
  logic [31:0] sum_next;

  assign word32   = 32'(ld_data);
  assign sum_next = chksum + word32;
  assign chk_ok   = (sum_next == chk_exp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chksum <= '0;
    end else if (accept) begin
      chksum <= sum_next;
    end
  end
`else
  logic unused_chk;

  assign unused_chk = ^chk_exp;
  assign chk_ok     = 1'b1;
  assign chksum     = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Only the final word or a full memory ends loading; ERR and RUN are both sticky.
  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (accept) begin
          if (ld_last) begin
            state_next = chk_ok ? RUN : ERR;
          end else if (at_end) begin
            state_next = ERR;
          end
        end
      end
      default: state_next = state;
    endcase
  end

  // Registered so ready stays low while reset is held and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q      <= 1'b0;
      loaded_count <= '0;
    end else begin
      ready_q <= (state_next == LOAD);
      if (accept) begin
        loaded_count <= loaded_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[loaded_count[ADDR_W-1:0]] <= ld_data;
    end
  end

  // Unloaded addresses and any fetch outside RUN read as NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_data <= '0;
    end else if (imem_en) begin
      imem_data <= (state == RUN && in_range) ? mem[imem_addr] : '0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=3): vector table, corner sequences, randomized rounds vs model.
// Follows IMEM_LOADER_CHKSUM_EN the same way the design does.
module tb_imem_loader;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic [31:0]       chk_exp = '0;
  logic              start;
  logic              load_err;
  logic [ADDR_W:0]   loaded_count;
  logic [31:0]       chksum;
  logic              imem_en = 1'b0;
  logic [ADDR_W-1:0] imem_addr = '0;
  logic [DATA_W-1:0] imem_data;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .chk_exp(chk_exp),
    .start(start), .load_err(load_err), .loaded_count(loaded_count),
    .chksum(chksum), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the loaded program as an array plus a few flags.
  logic [31:0] m_mem [DEPTH];
  int          m_count;
  logic [31:0] m_sum;
  bit          m_started;
  bit          m_error;
  bit          m_armed;
  logic [31:0] m_fetch;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        e;
    logic [2:0]  a;
    logic        rdy;
    logic        st;
    logic        er;
    logic [3:0]  cnt;
    logic [31:0] sum;
    logic [31:0] data;
  } vec_t;

  vec_t vec [13];

  function automatic bit m_ready();
    return m_armed && !m_started && !m_error;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".ld_ready"}, 32'(ld_ready), 32'(m_ready()));
    checkVal({tag, ".start"}, 32'(start), 32'(m_started));
    checkVal({tag, ".load_err"}, 32'(load_err), 32'(m_error));
    checkVal({tag, ".loaded_count"}, 32'(loaded_count), 32'(m_count));
    checkVal({tag, ".chksum"}, chksum, CHK_EN ? m_sum : 32'h0);
    checkVal({tag, ".imem_data"}, imem_data, m_fetch);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, returns #1 after it.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l,
                               input logic e, input logic [2:0] a);
    bit acc;
    ld_valid = v; ld_data = d; ld_last = l; imem_en = e; imem_addr = a;
    acc = m_ready() && v;
    if (e) m_fetch = (m_started && int'(a) < m_count) ? m_mem[a] : 32'h0;
    if (acc) begin
      m_mem[m_count % DEPTH] = d;
      m_sum = m_sum + d;
      m_count++;
      if (l) begin
        if (!CHK_EN || m_sum == chk_exp) m_started = 1'b1;
        else m_error = 1'b1;
      end else if (m_count == DEPTH) begin
        m_error = 1'b1;
      end
    end
    m_armed = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; imem_en = 1'b0;
    #2;
    m_count = 0; m_sum = '0; m_started = 0; m_error = 0; m_armed = 0; m_fetch = '0;
    checkOutput("reset");
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] s;
    int          idx;
    int          len;
    logic [31:0] words [10];

    vec[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,        32'h0};
    vec[1]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h11111111, 32'h0};
    vec[2]  = '{1'b1, 32'h22222222, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h33333333, 32'h0};
    vec[3]  = '{1'b1, 32'h33333333, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h0};
    vec[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h22222222};
    vec[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h0};
    vec[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h33333333};
    vec[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h33333333};
    vec[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h33333333};
    vec[9]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h33333333};
    vec[10] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h11111111};
    vec[11] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h0};
    vec[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 4'd3, 32'h66666666, 32'h33333333};

    // Basic load, fetch, out-of-range, hold and backpressure.
    doReset();
    chk_exp = 32'h66666666;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vec[i].v, vec[i].d, vec[i].l, vec[i].e, vec[i].a);
      checkVal($sformatf("vec%0d.ld_ready", i), 32'(ld_ready), 32'(vec[i].rdy));
      checkVal($sformatf("vec%0d.start", i), 32'(start), 32'(vec[i].st));
      checkVal($sformatf("vec%0d.load_err", i), 32'(load_err), 32'(vec[i].er));
      checkVal($sformatf("vec%0d.loaded_count", i), 32'(loaded_count), 32'(vec[i].cnt));
      checkVal($sformatf("vec%0d.chksum", i), chksum, CHK_EN ? vec[i].sum : 32'h0);
      checkVal($sformatf("vec%0d.imem_data", i), imem_data, vec[i].data);
    end

    // Overflow: DEPTH words without last.
    doReset();
    chk_exp = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h100 + i, 1'b0, 1'b0, 3'd0);
    checkVal("ovf.load_err", 32'(load_err), 32'd1);
    checkVal("ovf.start", 32'(start), 32'd0);
    checkVal("ovf.ld_ready", 32'(ld_ready), 32'd0);
    checkVal("ovf.loaded_count", 32'(loaded_count), DEPTH);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b1, 3'd0);
    checkVal("ovf_ignored.loaded_count", 32'(loaded_count), DEPTH);
    checkVal("ovf_fetch.imem_data", imem_data, 32'h0);
    checkOutput("ovf");

    // Last word lands exactly on the final index.
    doReset();
    s = '0;
    for (int i = 0; i < DEPTH; i++) s = s + 32'h100 + i;
    chk_exp = s;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h100 + i, i == DEPTH - 1, 1'b0, 3'd0);
    checkVal("full.start", 32'(start), 32'd1);
    checkVal("full.load_err", 32'(load_err), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 3'd7);
    checkVal("full_fetch.imem_data", imem_data, 32'h107);
    checkOutput("full");

    // Reset in the middle of a load restarts at index 0.
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h9ABCDEF0, 1'b0, 1'b0, 3'd0);
    doReset();
    chk_exp = 32'hAAAAAAAA;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'hAAAAAAAA, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 3'd0);
    checkVal("midrst.loaded_count", 32'(loaded_count), 32'd1);
    checkVal("midrst.start", 32'(start), 32'd1);
    checkVal("midrst.imem_data", imem_data, 32'hAAAAAAAA);

    // Checksum wrap: 1 + FFFFFFFF == 0.
    doReset();
    chk_exp = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 3'd0);
    checkVal("cks_good.start", 32'(start), 32'd1);
    checkVal("cks_good.chksum", chksum, 32'h0);
    doReset();
    chk_exp = 32'h1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 3'd0);
    checkVal("cks_bad_mid.chksum", chksum, CHK_EN ? 32'h1 : 32'h0);
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 3'd0);
    checkVal("cks_bad.load_err", 32'(load_err), CHK_EN ? 32'd1 : 32'd0);
    checkVal("cks_bad.start", 32'(start), CHK_EN ? 32'd0 : 32'd1);
    checkOutput("cks_bad");

    // Randomized rounds against the model.
    for (int r = 0; r < 8; r++) begin
      doReset();
      len = $urandom_range(1, 10);
      s = '0;
      for (int i = 0; i < len; i++) begin
        words[i] = $urandom;
        s = s + words[i];
      end
      chk_exp = ($urandom_range(0, 3) != 0) ? s : s + 32'h1;
      for (int c = 0; c < 40; c++) begin
        idx = m_count;
        if (idx < len && !m_started && !m_error)
          applyStimulus($urandom_range(0, 2) != 0, words[idx], idx == len - 1,
                        1'($urandom), 3'($urandom));
        else
          applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 3'($urandom));
        checkOutput($sformatf("rnd%0d.c%0d", r, c));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
